motor_pwm_driver: RTL

Downstream stage of the autopilot FSM: converts its 1-bit motor on/off command into a PWM drive signal for the motor power stage. Duty ramps linearly up and down (soft start/stop) so the on/off command never produces a current step. An emergency-stop input, driven by the autopilot's red-LED/emergency output, forces the drive off within one cycle.

---
 rtl/motor_pwm_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/motor_pwm_driver.sv
`default_nettype none
// ============================================================================
// motor_pwm_driver : soft-start/stop PWM motor drive with emergency stop.
// Ramp logic is built only when MOTOR_SOFTSTART_EN is defined.   Rev 1.0
// ============================================================================
module motor_pwm_driver #(
   parameter int PWM_BITS = 8,
   parameter int RAMP_DIV = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                motor_cmd_i,
   input  logic                estop_i,
   output logic                pwm_o,
   output logic [PWM_BITS-1:0] duty_o,
   output logic                at_speed_o,
   output logic                ramping_o
);

   localparam logic [PWM_BITS-1:0] C_DMAX     = '1;
   localparam logic [PWM_BITS-1:0] C_CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_RAMP_UP   = 2'd1,
      S_RUN       = 2'd2,
      S_RAMP_DOWN = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
   logic [PWM_BITS-1:0] r_pwm_cnt, r_duty_act;
   logic                r_pwm, r_at_speed;
   logic                w_wrap;

   assign w_wrap = (r_pwm_cnt == C_CNT_LAST);

   // Counter never stops, so estop release re-aligns with the running period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pwm_cnt  <= '0;
         r_duty_act <= '0;
         r_pwm      <= 1'b0;
      end else begin
         r_pwm_cnt <= w_wrap ? '0 : r_pwm_cnt + 1'b1;
         if (estop_i) begin
            r_duty_act <= '0;
            r_pwm      <= 1'b0;
         end else begin
            if (w_wrap)
               r_duty_act <= r_duty;
            r_pwm <= (r_pwm_cnt < r_duty_act);
         end
      end
   end

`ifdef MOTOR_SOFTSTART_EN
   localparam int            C_PRESC_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [C_PRESC_W-1:0] C_PRESC_LAST = C_PRESC_W'(RAMP_DIV - 1);

   logic [C_PRESC_W-1:0] r_presc, w_presc_nxt;
   logic                 r_ramping;
   logic                 w_tick;

   assign w_tick = (r_presc == C_PRESC_LAST);

   // Command changes take priority over a coincident tick: duty holds that cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      w_presc_nxt = '0;
      case (r_state)
         S_IDLE: begin
            w_duty_nxt = '0;
            if (motor_cmd_i)
               w_state_nxt = S_RAMP_UP;
         end
         S_RAMP_UP: begin
            if (!motor_cmd_i) begin
               w_state_nxt = S_RAMP_DOWN;
            end else if (w_tick) begin
               w_duty_nxt = (r_duty == C_DMAX) ? C_DMAX : r_duty + 1'b1;
               if (w_duty_nxt == C_DMAX)
                  w_state_nxt = S_RUN;
            end else begin
               w_presc_nxt = r_presc + 1'b1;
            end
         end
         S_RUN: begin
            w_duty_nxt = C_DMAX;
            if (!motor_cmd_i)
               w_state_nxt = S_RAMP_DOWN;
         end
         S_RAMP_DOWN: begin
            if (motor_cmd_i) begin
               w_state_nxt = S_RAMP_UP;
            end else if (w_tick) begin
               w_duty_nxt = (r_duty == '0) ? '0 : r_duty - 1'b1;
               if (w_duty_nxt == '0)
                  w_state_nxt = S_IDLE;
            end else begin
               w_presc_nxt = r_presc + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_duty_nxt  = '0;
         end
      endcase
      if (estop_i) begin
         w_state_nxt = S_IDLE;
         w_duty_nxt  = '0;
         w_presc_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_presc   <= '0;
         r_ramping <= 1'b0;
      end else begin
         r_presc   <= w_presc_nxt;
         r_ramping <= (w_state_nxt == S_RAMP_UP) || (w_state_nxt == S_RAMP_DOWN);
      end
   end

   assign ramping_o = r_ramping;
`else
   always_comb begin
      w_state_nxt = r_state;
      w_duty_nxt  = r_duty;
      case (r_state)
         S_IDLE: begin
            w_duty_nxt = '0;
            if (motor_cmd_i) begin
               w_state_nxt = S_RUN;
               w_duty_nxt  = C_DMAX;
            end
         end
         S_RUN: begin
            w_duty_nxt = C_DMAX;
            if (!motor_cmd_i) begin
               w_state_nxt = S_IDLE;
               w_duty_nxt  = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_duty_nxt  = '0;
         end
      endcase
      if (estop_i) begin
         w_state_nxt = S_IDLE;
         w_duty_nxt  = '0;
      end
   end

   assign ramping_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_duty     <= '0;
         r_at_speed <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_duty     <= w_duty_nxt;
         r_at_speed <= (w_state_nxt == S_RUN);
      end
   end

   assign pwm_o      = r_pwm;
   assign duty_o     = r_duty;
   assign at_speed_o = r_at_speed;

endmodule
`default_nettype wire
